// File: rtl/pkt_read.sv
// Packet-buffer read arbiter: four read channels served in fixed TDM slots, one RAM read
// per slot, returned data steered back to its requester. Optional per-channel return
// counters are enabled with the PKT_READ_STAT_EN macro.
module pkt_read #(
    parameter int RD_LAT = 2  // packet RAM read latency in clocks, legal 1..4
) (
    input  logic         clk_sys,
    input  logic         reset_n,

    input  logic         i_pkt_rd_req_p0,
    input  logic         i_pkt_rd_req_p1,
    input  logic         i_pkt_rd_req_p2,
    input  logic         i_pkt_rd_req_p3,
    input  logic [15:0]  iv_pkt_rd_bufadd_p0,
    input  logic [15:0]  iv_pkt_rd_bufadd_p1,
    input  logic [15:0]  iv_pkt_rd_bufadd_p2,
    input  logic [15:0]  iv_pkt_rd_bufadd_p3,

    output logic         o_pkt_rd_ack_p0,
    output logic         o_pkt_rd_ack_p1,
    output logic         o_pkt_rd_ack_p2,
    output logic         o_pkt_rd_ack_p3,
    output logic [133:0] ov_pkt_p0,
    output logic [133:0] ov_pkt_p1,
    output logic [133:0] ov_pkt_p2,
    output logic [133:0] ov_pkt_p3,
    output logic         o_pkt_wr_p0,
    output logic         o_pkt_wr_p1,
    output logic         o_pkt_wr_p2,
    output logic         o_pkt_wr_p3,

    output logic         o_ram_rd,
    output logic [15:0]  ov_ram_rdadd,
    input  logic [133:0] iv_ram_rdata,

    output logic [1:0]   ov_pkt_read_state
`ifdef PKT_READ_STAT_EN
    ,
    output logic [31:0]  ov_rd_cnt_p0,
    output logic [31:0]  ov_rd_cnt_p1,
    output logic [31:0]  ov_rd_cnt_p2,
    output logic [31:0]  ov_rd_cnt_p3
`endif
);

    typedef enum logic [1:0] {
        RD_CH0_S = 2'd0,
        RD_CH1_S = 2'd1,
        RD_CH2_S = 2'd2,
        RD_CH3_S = 2'd3
    } slot_e;

    typedef struct packed {
        logic       vld;
        logic [1:0] ch;
    } tag_t;

    slot_e             state_q, state_d;
    logic [1:0]        slot_w;
    logic              slot_ok_w;

    logic [3:0]        req_w;
    logic [15:0]       addr_w [4];

    logic              ram_rd_q, ram_rd_d;
    logic [15:0]       ram_rdadd_q, ram_rdadd_d;
    logic [1:0]        rd_ch_q, rd_ch_d;
    logic [3:0]        ack_q, ack_d;

    tag_t              tag_q [RD_LAT];
    tag_t              tag_exit_w;

    logic [3:0]        wr_q, wr_d;
    logic [3:0][133:0] pkt_q;

    assign req_w     = {i_pkt_rd_req_p3, i_pkt_rd_req_p2, i_pkt_rd_req_p1, i_pkt_rd_req_p0};
    assign addr_w[0] = iv_pkt_rd_bufadd_p0;
    assign addr_w[1] = iv_pkt_rd_bufadd_p1;
    assign addr_w[2] = iv_pkt_rd_bufadd_p2;
    assign addr_w[3] = iv_pkt_rd_bufadd_p3;
    assign slot_w    = state_q;

    // Slot sequencing and grant decision for the channel owning the current slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = RD_CH0_S;
        slot_ok_w   = 1'b0;
        ram_rd_d    = 1'b0;
        ram_rdadd_d = '0;
        rd_ch_d     = 2'd0;
        ack_d       = '0;
        case (state_q)
            RD_CH0_S: begin state_d = RD_CH1_S; slot_ok_w = 1'b1; end
            RD_CH1_S: begin state_d = RD_CH2_S; slot_ok_w = 1'b1; end
            RD_CH2_S: begin state_d = RD_CH3_S; slot_ok_w = 1'b1; end
            RD_CH3_S: begin state_d = RD_CH0_S; slot_ok_w = 1'b1; end
            default:  begin state_d = RD_CH0_S; slot_ok_w = 1'b0; end
        endcase
        if (slot_ok_w && req_w[slot_w]) begin
            ram_rd_d        = 1'b1;
            ram_rdadd_d     = addr_w[slot_w];
            rd_ch_d         = slot_w;
            ack_d[slot_w]   = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RD_CH0_S;
            ram_rd_q    <= 1'b0;
            ram_rdadd_q <= '0;
            rd_ch_q     <= 2'd0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            ram_rd_q    <= ram_rd_d;
            ram_rdadd_q <= ram_rdadd_d;
            rd_ch_q     <= rd_ch_d;
            ack_q       <= ack_d;
        end
    end

    // Tag pipeline tracks each issued read until its RAM data is valid.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this small array is reset on purpose: in-flight reads must be dropped on reset.
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: ram_rd_q, ch: rd_ch_q};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_exit_w = tag_q[RD_LAT-1];

    always_comb begin
        wr_d = '0;
        if (tag_exit_w.vld) begin
            wr_d[tag_exit_w.ch] = 1'b1;
        end
    end

    // Return registers hold zero whenever their channel is not being written.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            pkt_q <= '0;
        end else begin
            wr_q <= wr_d;
            for (int j = 0; j < 4; j++) begin
                pkt_q[j] <= wr_d[j] ? iv_ram_rdata : '0;
            end
        end
    end

    assign o_ram_rd          = ram_rd_q;
    assign ov_ram_rdadd      = ram_rdadd_q;
    assign ov_pkt_read_state = state_q;

    assign o_pkt_rd_ack_p0 = ack_q[0];
    assign o_pkt_rd_ack_p1 = ack_q[1];
    assign o_pkt_rd_ack_p2 = ack_q[2];
    assign o_pkt_rd_ack_p3 = ack_q[3];

    assign o_pkt_wr_p0 = wr_q[0];
    assign o_pkt_wr_p1 = wr_q[1];
    assign o_pkt_wr_p2 = wr_q[2];
    assign o_pkt_wr_p3 = wr_q[3];

    assign ov_pkt_p0 = pkt_q[0];
    assign ov_pkt_p1 = pkt_q[1];
    assign ov_pkt_p2 = pkt_q[2];
    assign ov_pkt_p3 = pkt_q[3];

`ifdef PKT_READ_STAT_EN
    logic [3:0][31:0] rd_cnt_q;

    // Completed-return counters; they wrap naturally at 2^32.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                rd_cnt_q[j] <= rd_cnt_q[j] + 32'(wr_q[j]);
            end
        end
    end

    assign ov_rd_cnt_p0 = rd_cnt_q[0];
    assign ov_rd_cnt_p1 = rd_cnt_q[1];
    assign ov_rd_cnt_p2 = rd_cnt_q[2];
    assign ov_rd_cnt_p3 = rd_cnt_q[3];
`endif

endmodule

// File: doc/pkt_read.md
Name: pkt_read

Overview:
- Centralized packet-buffer read arbiter for the 4-port TSN switch, in pkt_centralized_buffer.
- Serves four output-port read channels in fixed TDM round-robin, one slot per clock.
- Issues one read per granted slot to the shared packet RAM.
- Tracks each outstanding read through the RAM read latency and returns the 134-bit word to the channel that requested it.

Parameters:
RD_LAT, 2, packet RAM read latency in clocks from o_ram_rd to valid iv_ram_rdata. Legal range 1..4.

Ports:
clk_sys  input  1  system clock
reset_n  input  1  asynchronous active-low reset
i_pkt_rd_req_pN  input  1  channel N read request, level; N=0..3
iv_pkt_rd_bufadd_pN  input  16  channel N buffer address; valid while request is high
o_pkt_rd_ack_pN  output  1  channel N request accepted, 1-cycle pulse
ov_pkt_pN  output  134  channel N returned packet word
o_pkt_wr_pN  output  1  channel N returned word valid, 1-cycle pulse
o_ram_rd  output  1  RAM read enable
ov_ram_rdadd  output  16  RAM read address
iv_ram_rdata  input  134  RAM read data; valid RD_LAT cycles after o_ram_rd
ov_pkt_read_state  output  2  current TDM slot (debug)

Behaviour:
- Clocking and reset:
  - Single clock domain clk_sys.
  - reset_n is asynchronous and active-low.
  - All outputs reset to 0; ov_pkt_read_state resets to slot 0.
- Slot state machine:
  - States rd_ch0_s=0, rd_ch1_s=1, rd_ch2_s=2, rd_ch3_s=3.
  - Unconditional advance 0→1→2→3→0 every clock. Each channel is visited once per 4 clocks.
- Grant in slot k (cycle T):
  - If i_pkt_rd_req_pk=1, then at T+1: o_ram_rd=1, ov_ram_rdadd=iv_pkt_rd_bufadd_pk, o_pkt_rd_ack_pk=1.
  - Otherwise at T+1: o_ram_rd=0 and ov_ram_rdadd=0.
- Ack:
  - Each o_pkt_rd_ack_pk is high for exactly one cycle; it is cleared in the following slot.
  - The requester must drop its request, or present the next address, before its next slot. A request still high at the next slot is a new read.
- Tag pipeline:
  - Shift register of depth RD_LAT carries {valid, 2-bit channel id}, aligned with o_ram_rd.
  - When the tag exits with valid=1 (cycle T+1+RD_LAT), the block registers iv_ram_rdata into ov_pkt_pj for tag channel j and pulses o_pkt_wr_pj for one cycle.
- Latency: request sampled at T → data on ov_pkt_pj at T+2+RD_LAT. With default RD_LAT=2, that is T+4.
- Idle data:
  - ov_pkt_pN is driven to 0 whenever o_pkt_wr_pN=0.
  - At most one o_pkt_wr_pN is high in any cycle.
- Throughput:
  - Maximum one RAM read per clock.
  - Maximum one read per channel per 4 clocks.
  - Back-to-back reads from different channels in consecutive slots are returned in issue order, with no gaps.
- Simultaneous requests: all four channels requesting is not a conflict; they are served in slot order starting from the current state.
- Illegal state: any state value outside 0..3 (unreachable) clears all acks and outputs and goes to slot 0.
- Reset mid-operation:
  - The tag pipeline is cleared, so in-flight reads are discarded and no o_pkt_wr_pN is produced for them.
  - After reset deassertion, slot 0 is the first slot evaluated.
- Address: passed through unmodified, with no range check. Address 16'hFFFF is legal.

Optional Feature:
- Macro PKT_READ_STAT_EN.
- When defined:
  - Adds four output ports ov_rd_cnt_pN, 32 bits each.
  - Each counts completed returns (o_pkt_wr_pN pulses) for its channel.
  - Counters reset to 0 on reset_n and wrap from 32'hFFFFFFFF to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset then idle, all requests 0 for 20 clocks → o_ram_rd=0, all acks and o_pkt_wr_pN=0, ov_pkt_read_state cycles 0,1,2,3,0.
2. Channel 2 requests address 16'h0123 while the RAM model returns data=addr-tagged pattern, RD_LAT=2 → o_ram_rd with address 0x0123 one cycle after slot 2, o_pkt_rd_ack_p2 pulse in the same cycle, o_pkt_wr_p2 with ov_pkt_p2=pattern(0x0123) 4 cycles after the sampled slot; other channels silent.
3. All four channels request continuously with distinct addresses 0x0010..0x0013 → o_ram_rd=1 every cycle, addresses rotate 0x10,0x11,0x12,0x13, each channel receives exactly its own data once per 4 clocks.
4. Channel 1 requests with address 16'hFFFF and reset_n is asserted 1 cycle after the RAM read issues → no o_pkt_wr_p1 after release; first post-reset slot is 0.
5. Rerun scenario 3 with RD_LAT=1 and RD_LAT=4 → return latency 3 and 6 clocks respectively, ordering preserved.
6. With PKT_READ_STAT_EN defined, 10 reads on channel 0 → ov_rd_cnt_p0=10 and the other counters 0. With the counter preloaded via force to 32'hFFFFFFFF, one more return → 0.
